// File: rtl/jk_pkg.sv
// jk_pkg: shared op/state encodings and expected-q helper for the JK command sequencer
package jk_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_CHECK = 2'b10
    } state_t;

    // Value q should hold after the command's drive window, given q at pop time.
    function automatic logic exp_q_of(input op_t op, input logic q);
        return op == OP_HOLD  ? q    :
               op == OP_RESET ? 1'b0 :
               op == OP_SET   ? 1'b1 : ~q;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous 2-bit command FIFO with full/empty flags
module jk_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_data,
    input  logic       rd_en,
    output logic [1:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; empty gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: turns queued HOLD/RESET/SET/TOGGLE commands into timed j/k windows and checks q
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 1,
    parameter int CHK_EN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    input  logic       q_fb,
    input  logic       err_clr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(HOLD_CYC + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    op_t           op_r, op_n;
    logic          exp_q, exp_q_n;
    logic          j_n, k_n, err_n;
    logic          pop, full, empty, mismatch;
    logic [1:0]    fifo_dout;

    jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmd_valid),
        .wr_data (cmd_op),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (full),
        .empty   (empty)
    );

    // State, hold counter, latched command, registered j/k drive and sticky err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_r  <= OP_HOLD;
            exp_q <= 1'b0;
            j     <= 1'b0;
            k     <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_r  <= op_n;
            exp_q <= exp_q_n;
            j     <= j_n;
            k     <= k_n;
            err   <= err_n;
        end
    end

    // Next state: pop from IDLE or CHECK, count out the drive window, then check.
    always_comb begin
        pop      = !empty && (state == S_IDLE || state == S_CHECK);
        op_n     = pop ? op_t'(fifo_dout) : op_r;
        exp_q_n  = pop ? exp_q_of(op_t'(fifo_dout), q_fb) : exp_q;
        cnt_n    = pop ? '0 : (state == S_DRIVE ? cnt + 1'b1 : cnt);
        state_n  = pop                                          ? S_DRIVE :
                   state == S_CHECK                             ? S_IDLE  :
                   state == S_DRIVE && cnt == CW'(HOLD_CYC - 1) ? S_CHECK : state;
        mismatch = CHK_EN != 0 && state == S_CHECK && q_fb != exp_q;
        err_n    = mismatch || (err && !err_clr);
    end

    // Outputs: j/k are pre-computed from the next state so they register in step with DRIVE.
    always_comb begin
        j_n       = state_n == S_DRIVE && op_n[1];
        k_n       = state_n == S_DRIVE && op_n[0];
        done      = state == S_CHECK;
        busy      = state != S_IDLE || !empty;
        cmd_ready = !full;
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed checks of the sequencer driving a JK element model
module tb_jk_cmd_sequencer;

    localparam int HOLD_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready, j, k, q_fb, busy, done, err;
    logic       err_clr = 1'b0;
    logic       force_q = 1'b0;
    logic       q;
    logic [1:0] jk_prev;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(4), .HOLD_CYC(HOLD_CYC), .CHK_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .err_clr   (err_clr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // JK element model: toggles once when j=k=1 is first applied, so a held
    // TOGGLE window yields a single inversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= 1'b0;
            jk_prev <= 2'b00;
        end else begin
            jk_prev <= {j, k};
            if (j && k) begin
                if (jk_prev != 2'b11) q <= ~q;
            end else if (j) q <= 1'b1;
            else if (k) q <= 1'b0;
        end
    end

    assign q_fb = force_q ? 1'b0 : q;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic ej, input logic ek,
                           input logic eq, input logic eerr, input string tag);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < HOLD_CYC; c++) begin
            @(negedge clk);
            check({tag, "_j"}, 32'(j), 32'(ej));
            check({tag, "_k"}, 32'(k), 32'(ek));
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_jk_chk"}, 32'({j, k}), 0);
        check({tag, "_q"}, 32'(q_fb), 32'(eq));
        @(negedge clk);
        check({tag, "_done_off"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 32'(eerr));
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic [1:0] ops [7];
        int         done_at [$];
        int         seen;
        ops = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

        #10 rst = 1'b1;
        @(negedge clk);
        check("rst_j", 32'(j), 0);
        check("rst_k", 32'(k), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_done", 32'(done), 0);

        run_cmd(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, "set");
        run_cmd(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
        run_cmd(2'b11, 1'b1, 1'b1, 1'b1, 1'b0, "toggle");
        run_cmd(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, "hold");

        // Seven back-to-back valids: queue fills after the sixth push, the seventh is dropped.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ops[0];
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 4) check("full_ready_n4", 32'(cmd_ready), 1);
            if (i == 5) check("full_ready_n5", 32'(cmd_ready), 0);
            if (done) done_at.push_back(i);
            cmd_valid = (i + 1) < 7;
            cmd_op    = ops[(i + 1) % 7];
        end
        check("full_done_count", 32'(done_at.size()), 6);
        if (done_at.size() > 0) check("full_first_done", 32'(done_at[0]), 3);
        for (int i = 1; i < done_at.size(); i++)
            check("full_done_gap", 32'(done_at[i] - done_at[i-1]), 3);
        check("full_busy_end", 32'(busy), 0);
        check("full_q_end", 32'(q_fb), 0);

        force_q = 1'b1;
        run_cmd(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, "mis");
        force_q = 1'b0;
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 0);
        force_q = 1'b1;
        err_clr = 1'b1;
        run_cmd(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, "mis_clr");
        err_clr = 1'b0;
        force_q = 1'b0;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_j", 32'(j), 1);
        #1 rst = 1'b0;
        #1;
        check("abort_jk", 32'({j, k}), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(cmd_ready), 1);
        check("abort_err", 32'(err), 0);
        seen = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 0);
        run_cmd(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
